// File: rtl/down_sampler_nxn.sv
// NxN video down-sampler (N = 1, 2 or 4 chosen per frame), one-cycle output latency.
// Define DS_AVG_EN to average each NxN group's row pixels instead of keeping the first pixel.
module down_sampler_nxn #(
  parameter int H_SIZE = 1920,
  parameter int V_SIZE = 1080,
  parameter int CH_NUM = 4,
  parameter int CH_W   = 8
) (
  input  logic                     I_clk,
  input  logic                     I_rst_n,
  input  logic [1:0]               I_ratio,
  input  logic                     I_rgb_vs,
  input  logic                     I_rgb_de,
  input  logic [CH_NUM*CH_W-1:0]   I_rgb_data,
  output logic                     O_rgb_vs,
  output logic                     O_rgb_de,
  output logic [CH_NUM*CH_W-1:0]   O_rgb_data,
  output logic [1:0]               O_ratio_act
);
  localparam int PW = CH_NUM * CH_W;
  localparam int CW = $clog2(H_SIZE);
  localparam int RW = $clog2(V_SIZE);

  logic          r_vs_d;
  logic          r_armed;
  logic [1:0]    r_ratio;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_de;
  logic [PW-1:0] r_data;

  logic          w_vs_rise;
  logic [1:0]    w_mask;
  logic          w_pix;
  logic          w_first;
  logic          w_last;
  logic          w_keep;
  logic [PW-1:0] w_out;

  assign w_vs_rise = I_rgb_vs & ~r_vs_d;
  // N-1 as a mask; the active ratio code doubles as log2(N).
  assign w_mask    = (r_ratio == 2'd2) ? 2'd3 : (r_ratio == 2'd1) ? 2'd1 : 2'd0;
  // Pixels are ignored until a frame start has been seen since reset.
  assign w_pix     = I_rgb_de & r_armed & ~w_vs_rise;
  assign w_first   = (r_col[1:0] & w_mask) == 2'd0;
  assign w_last    = (r_col[1:0] & w_mask) == w_mask;
  assign w_keep    = (r_row[1:0] & w_mask) == 2'd0;

`ifdef DS_AVG_EN
  logic [CH_NUM-1:0][CH_W+1:0] r_acc;
  logic [CH_NUM-1:0][CH_W+1:0] w_sum;

  always_comb begin
    w_sum = '0;
    w_out = '0;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      w_sum[ch] = (w_first ? '0 : r_acc[ch]) + (CH_W+2)'(I_rgb_data[ch*CH_W +: CH_W]);
      w_out[ch*CH_W +: CH_W] = CH_W'(w_sum[ch] >> r_ratio);
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)       r_acc <= '0;
    else if (w_vs_rise) r_acc <= '0;
    else if (w_pix)     r_acc <= w_sum;
  end
`else
  logic [PW-1:0] r_first;

  assign w_out = w_first ? I_rgb_data : r_first;

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)               r_first <= '0;
    else if (w_vs_rise)         r_first <= '0;
    else if (w_pix && w_first)  r_first <= I_rgb_data;
  end
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_d  <= 1'b0;
      r_armed <= 1'b0;
      r_ratio <= 2'd0;
      r_col   <= '0;
      r_row   <= '0;
      r_de    <= 1'b0;
      r_data  <= '0;
    end else begin
      r_vs_d <= I_rgb_vs;
      r_de   <= 1'b0;
      if (w_vs_rise) begin
        r_ratio <= (I_ratio == 2'd3) ? 2'd0 : I_ratio;
        r_armed <= 1'b1;
        r_col   <= '0;
        r_row   <= '0;
      end else if (w_pix) begin
        if (r_col == CW'(H_SIZE - 1)) begin
          r_col <= '0;
          r_row <= (r_row == RW'(V_SIZE - 1)) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
        if (w_keep && w_last) begin
          r_de   <= 1'b1;
          r_data <= w_out;
        end
      end
    end
  end

  assign O_rgb_vs    = r_vs_d;
  assign O_rgb_de    = r_de;
  assign O_rgb_data  = r_data;
  assign O_ratio_act = r_ratio;
endmodule

// File: tb/tb_down_sampler_nxn.sv
// Directed bench for down_sampler_nxn with an 8x4 frame; expectations cover both DS_AVG_EN builds.
module tb_down_sampler_nxn;
  logic        I_clk = 1'b0;
  logic        I_rst_n;
  logic [1:0]  I_ratio;
  logic        I_rgb_vs;
  logic        I_rgb_de;
  logic [31:0] I_rgb_data;
  logic        O_rgb_vs;
  logic        O_rgb_de;
  logic [31:0] O_rgb_data;
  logic [1:0]  O_ratio_act;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_out;
  logic [1:0]  exp_ratio;

  down_sampler_nxn #(.H_SIZE(8), .V_SIZE(4), .CH_NUM(4), .CH_W(8)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n), .I_ratio(I_ratio),
    .I_rgb_vs(I_rgb_vs), .I_rgb_de(I_rgb_de), .I_rgb_data(I_rgb_data),
    .O_rgb_vs(O_rgb_vs), .O_rgb_de(O_rgb_de), .O_rgb_data(O_rgb_data),
    .O_ratio_act(O_ratio_act)
  );

  always #5 I_clk = ~I_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One input cycle; outputs are sampled 1 time unit after the edge that registers it.
  task automatic px(input logic vs, input logic de, input logic [31:0] d,
                    input logic exp_de, input logic [31:0] exp_d, input string tag);
    @(negedge I_clk);
    I_rgb_vs   = vs;
    I_rgb_de   = de;
    I_rgb_data = d;
    @(posedge I_clk);
    #1;
    if (exp_de) last_out = exp_d;
    chk({tag, "_vs"},    32'(O_rgb_vs),    32'(vs));
    chk({tag, "_de"},    32'(O_rgb_de),    32'(exp_de));
    chk({tag, "_data"},  O_rgb_data,       last_out);
    chk({tag, "_ratio"}, 32'(O_ratio_act), 32'(exp_ratio));
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] e;
    I_rst_n    = 1'b0;
    I_ratio    = 2'd2;
    I_rgb_vs   = 1'b1;
    I_rgb_de   = 1'b1;
    I_rgb_data = 32'hDEADBEEF;
    last_out   = 32'h0;
    exp_ratio  = 2'd0;

    // Reset state with busy inputs
    repeat (3) @(posedge I_clk);
    #1;
    chk("rst_vs",    32'(O_rgb_vs),    32'h0);
    chk("rst_de",    32'(O_rgb_de),    32'h0);
    chk("rst_data",  O_rgb_data,       32'h0);
    chk("rst_ratio", 32'(O_ratio_act), 32'h0);
    @(negedge I_clk);
    I_rgb_vs = 1'b0;
    I_rgb_de = 1'b0;
    I_rst_n  = 1'b1;

    // Pixels before any frame start are ignored
    px(1'b0, 1'b1, 32'h11, 1'b0, 32'h0, "pre0");
    px(1'b0, 1'b1, 32'h22, 1'b0, 32'h0, "pre1");

    // 1x bypass, full 8x4 frame
    I_ratio = 2'd0;
    px(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "vs_r0");
    for (int i = 0; i < 32; i++) begin
      d = 32'h0A000000 | (32'(i) * 32'h00010101);
      px(1'b0, 1'b1, d, 1'b1, d, "bypass");
    end
    px(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, "hold");

    // Ratio code 3 behaves as 1x
    I_ratio = 2'd3;
    px(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "vs_r3");
    px(1'b0, 1'b1, 32'h33, 1'b1, 32'h33, "r3_a");
    px(1'b0, 1'b1, 32'h44, 1'b1, 32'h44, "r3_b");

    // 2x: row 0 emits cols 1,3,5,7; row 1 silent; ratio change mid-frame ignored
    I_ratio   = 2'd1;
    exp_ratio = 2'd1;
    px(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "vs_r1");
    for (int c = 0; c < 8; c++) begin
      d = {4{8'(c)}};
      e = {4{8'(c - 1)}};
      px(1'b0, 1'b1, d, c[0], e, "r1_row0");
    end
    I_ratio = 2'd2;
    for (int c = 0; c < 8; c++) begin
      d = {4{8'(c + 8)}};
      px(1'b0, 1'b1, d, 1'b0, 32'h0, "r1_row1");
    end
    // Row 2 with a de gap after every pixel
    for (int c = 0; c < 8; c++) begin
      d = {4{8'(c + 16)}};
      e = {4{8'(c + 15)}};
      px(1'b0, 1'b1, d, c[0], e, "r1_gap_px");
      px(1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0, "r1_gap_idle");
    end

    // 4x: partial group discarded by a new frame start
    exp_ratio = 2'd2;
    px(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "vs_r2a");
    px(1'b0, 1'b1, 32'h09, 1'b0, 32'h0, "part0");
    px(1'b0, 1'b1, 32'h09, 1'b0, 32'h0, "part1");
    px(1'b0, 1'b1, 32'h09, 1'b0, 32'h0, "part2");
    px(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "vs_r2b");
    px(1'b0, 1'b1, 32'hFF000801, 1'b0, 32'h0, "g0_c0");
    px(1'b0, 1'b1, 32'hFF000802, 1'b0, 32'h0, "g0_c1");
    px(1'b0, 1'b1, 32'hFF000803, 1'b0, 32'h0, "g0_c2");
`ifdef DS_AVG_EN
    e = 32'hFF000803;
`else
    e = 32'hFF000801;
`endif
    px(1'b0, 1'b1, 32'hFF000806, 1'b1, e, "g0_c3");
    for (int c = 4; c < 8; c++)
      px(1'b0, 1'b1, 32'hFF000808, (c == 7), 32'hFF000808, "g1");
    for (int c = 0; c < 8; c++)
      px(1'b0, 1'b1, 32'h12345678, 1'b0, 32'h0, "r2_row1");

    // Reset mid-frame aborts; output waits for the next frame start
    @(negedge I_clk);
    I_rgb_de = 1'b1;
    I_rst_n  = 1'b0;
    #1;
    chk("mrst_de",    32'(O_rgb_de),    32'h0);
    chk("mrst_data",  O_rgb_data,       32'h0);
    chk("mrst_ratio", 32'(O_ratio_act), 32'h0);
    last_out  = 32'h0;
    exp_ratio = 2'd0;
    @(negedge I_clk);
    I_rgb_de = 1'b0;
    I_rst_n  = 1'b1;
    I_ratio  = 2'd1;
    px(1'b0, 1'b1, 32'h55, 1'b0, 32'h0, "post0");
    px(1'b0, 1'b1, 32'h66, 1'b0, 32'h0, "post1");
    exp_ratio = 2'd1;
    px(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, "vs_post");
    px(1'b0, 1'b1, 32'h10203040, 1'b0, 32'h0, "post_c0");
`ifdef DS_AVG_EN
    e = 32'h11213141;
`else
    e = 32'h10203040;
`endif
    px(1'b0, 1'b1, 32'h12223242, 1'b1, e, "post_c1");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
